// File: rtl/divisor8_pkg.sv
// Shared constants and FSM state encoding for the 8-bit restoring divider.
package divisor8_pkg;
  localparam int WIDTH = 8;
  localparam int ITER  = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
endpackage

// File: rtl/divisor8_subtrator8.sv
// 8-bit ripple-borrow subtractor: d[7:0] = x - y, d[8] = borrow out.
module subtrator8 (
  input  logic [7:0] x,
  input  logic [7:0] y,
  output logic [8:0] d
);
  logic br;

  always_comb begin
    br = 1'b0;
    d  = '0;
    for (int i = 0; i < 8; i++) begin
      d[i] = x[i] ^ y[i] ^ br;
      br   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br);
    end
    d[8] = br;
  end
endmodule

// File: rtl/divisor8.sv
// Unsigned 8-bit restoring divider, one quotient bit per clock, MSB first.
// Define DIVISOR8_DIVZERO_EN to add the err port and a 1-cycle divide-by-zero path.
module divisor8
  import divisor8_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
`ifdef DIVISOR8_DIVZERO_EN
  ,
  output logic             err
`endif
);
  logic [1:0]       state;
  logic [2:0]       cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_lat;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] q_acc;
  logic [WIDTH-1:0] p_shift;
  logic [WIDTH-1:0] p_next;
  logic [WIDTH:0]   diff;
  logic             no_borrow;
  logic             last_iter;
  logic             accept;

  // P never exceeds the dividend prefix seen so far, so 8 bits hold the shifted value.
  assign p_shift = {p[WIDTH-2:0], a_sh[WIDTH-1]};

  subtrator8 u_sub (
    .x (p_shift),
    .y (b_lat),
    .d (diff)
  );

  assign no_borrow = ~diff[WIDTH];
  assign p_next    = no_borrow ? diff[WIDTH-1:0] : p_shift;
  assign last_iter = (cnt == 3'(ITER - 1));
  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign busy      = (state == CALC);
  assign done      = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      a_sh  <= '0;
      b_lat <= '0;
      p     <= '0;
      q_acc <= '0;
      q     <= '0;
      r     <= '0;
`ifdef DIVISOR8_DIVZERO_EN
      err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            a_sh  <= a;
            b_lat <= b;
            p     <= '0;
            q_acc <= '0;
            cnt   <= '0;
`ifdef DIVISOR8_DIVZERO_EN
            // Divide-by-zero short-circuits straight to a result.
            if (b == '0) begin
              state <= DONE;
              q     <= '1;
              r     <= a;
              err   <= 1'b1;
            end else begin
              state <= CALC;
            end
`else
            state <= CALC;
`endif
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          a_sh  <= a_sh << 1;
          p     <= p_next;
          q_acc <= {q_acc[WIDTH-2:0], no_borrow};
          cnt   <= cnt + 3'd1;
          if (last_iter) begin
            state <= DONE;
            q     <= {q_acc[WIDTH-2:0], no_borrow};
            r     <= p_next;
`ifdef DIVISOR8_DIVZERO_EN
            err   <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_divisor8.sv
// Directed self-checking bench for divisor8 (works with or without DIVISOR8_DIVZERO_EN).
module tb_divisor8;
  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] q;
  logic [7:0] r;
`ifdef DIVISOR8_DIVZERO_EN
  logic       err;
`endif

  int tests;
  int fails;
  logic [7:0] prev_q;
  logic [7:0] prev_r;

  divisor8 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .r     (r)
`ifdef DIVISOR8_DIVZERO_EN
    ,
    .err   (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Start in the current cycle (c0), then verify c1..c8 busy and c9 result.
  task automatic run_div(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                         input logic [7:0] eq, input logic [7:0] er);
    a = ta;
    b = tb_v;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk({tag, "_busy"}, 16'(busy), 16'd1);
      chk({tag, "_done_lo"}, 16'(done), 16'd0);
      chk({tag, "_q_hold"}, 16'(q), 16'(prev_q));
      chk({tag, "_r_hold"}, 16'(r), 16'(prev_r));
      tick();
    end
    chk({tag, "_done"}, 16'(done), 16'd1);
    chk({tag, "_busy_lo"}, 16'(busy), 16'd0);
    chk({tag, "_q"}, 16'(q), 16'(eq));
    chk({tag, "_r"}, 16'(r), 16'(er));
`ifdef DIVISOR8_DIVZERO_EN
    chk({tag, "_err"}, 16'(err), 16'd0);
`endif
    prev_q = eq;
    prev_r = er;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    prev_q = 8'd0;
    prev_r = 8'd0;
    rst = 1'b1;
    start = 1'b0;
    a = 8'd0;
    b = 8'd0;
    tick();
    tick();
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_q", 16'(q), 16'd0);
    chk("rst_r", 16'(r), 16'd0);
`ifdef DIVISOR8_DIVZERO_EN
    chk("rst_err", 16'(err), 16'd0);
`endif
    rst = 1'b0;

    run_div("d200_7", 8'd200, 8'd7, 8'd28, 8'd4);
    tick();
    chk("d200_7_c10_done", 16'(done), 16'd0);
    chk("d200_7_c10_busy", 16'(busy), 16'd0);

    run_div("d255_1", 8'd255, 8'd1, 8'd255, 8'd0);
    run_div("d5_9", 8'd5, 8'd9, 8'd0, 8'd5);
    run_div("d255_200", 8'd255, 8'd200, 8'd1, 8'd55);
    tick();

    // start during CALC is ignored; start in DONE is accepted
    a = 8'd200;
    b = 8'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a = 8'd10;
    b = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 4; c <= 8; c++) begin
      chk("ign_busy", 16'(busy), 16'd1);
      chk("ign_done_lo", 16'(done), 16'd0);
      tick();
    end
    chk("ign_done", 16'(done), 16'd1);
    chk("ign_q", 16'(q), 16'd28);
    chk("ign_r", 16'(r), 16'd4);
    a = 8'd10;
    b = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("redo_done_lo", 16'(done), 16'd0);
    chk("redo_busy", 16'(busy), 16'd1);
    chk("redo_q_hold", 16'(q), 16'd28);
    for (int c = 11; c <= 18; c++) tick();
    chk("redo_done", 16'(done), 16'd1);
    chk("redo_q", 16'(q), 16'd5);
    chk("redo_r", 16'(r), 16'd0);
    tick();

    // reset in c4 aborts the running division
    a = 8'd200;
    b = 8'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 16'(busy), 16'd0);
    chk("abort_done", 16'(done), 16'd0);
    chk("abort_q", 16'(q), 16'd0);
    chk("abort_r", 16'(r), 16'd0);
    for (int c = 0; c < 10; c++) begin
      chk("abort_no_done", 16'(done), 16'd0);
      tick();
    end
    prev_q = 8'd0;
    prev_r = 8'd0;

    // divide by zero
`ifdef DIVISOR8_DIVZERO_EN
    a = 8'd37;
    b = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("dz_done", 16'(done), 16'd1);
    chk("dz_busy", 16'(busy), 16'd0);
    chk("dz_err", 16'(err), 16'd1);
    chk("dz_q", 16'(q), 16'd255);
    chk("dz_r", 16'(r), 16'd37);
    tick();
    chk("dz_done_lo", 16'(done), 16'd0);
    chk("dz_err_hold", 16'(err), 16'd1);
    prev_q = 8'd255;
    prev_r = 8'd37;
    run_div("dz_clear", 8'd200, 8'd7, 8'd28, 8'd4);
`else
    run_div("dz", 8'd37, 8'd0, 8'd255, 8'd37);
`endif
    tick();

    // reset wins over a simultaneous start
    a = 8'd9;
    b = 8'd3;
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    chk("rs_busy", 16'(busy), 16'd0);
    chk("rs_done", 16'(done), 16'd0);
    chk("rs_q", 16'(q), 16'd0);
    tick();
    chk("rs_busy_after", 16'(busy), 16'd0);
    chk("rs_done_after", 16'(done), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
